// File: rtl/apb_cmd_arbiter.sv
// Round-robin arbiter that turns per-channel read/write requests into single-cycle FIFO commands.
// Optional macro ARB_WRITE_PRIORITY_EN: eligible writes are served ahead of eligible reads.
module apb_cmd_arbiter #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH-1:0]         req_write,
    input  logic [NUM_CH*ADDR_W-1:0]  req_addr,
    input  logic [NUM_CH*DATA_W-1:0]  req_wdata,
    input  logic                      fifo_full,
    output logic [NUM_CH-1:0]         grant,
    output logic                      cmd_push,
    output logic [1:0]                cmd_op,
    output logic [$clog2(NUM_CH)-1:0] cmd_ch,
    output logic [ADDR_W-1:0]         cmd_addr,
    output logic [DATA_W-1:0]         cmd_wdata,
    output logic [15:0]               stall_cnt
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10
    } cmd_op_e;

    logic [NUM_CH-1:0] r_grant;
    logic              r_cmdPush;
    cmd_op_e           r_cmdOp;
    logic [CH_W-1:0]   r_cmdCh;
    logic [ADDR_W-1:0] r_cmdAddr;
    logic [DATA_W-1:0] r_cmdWdata;
    logic [15:0]       r_stallCnt;
    logic [CH_W-1:0]   r_lastGrant;

    logic [ADDR_W-1:0] w_addrArr [NUM_CH];
    logic [DATA_W-1:0] w_dataArr [NUM_CH];
    logic [NUM_CH-1:0] w_elig;
    logic [NUM_CH-1:0] w_cand;
    logic              w_issue;
    logic              w_stall;
    logic              w_found;
    logic [CH_W-1:0]   w_scanIdx;
    logic [CH_W-1:0]   w_selIdx;

    logic [NUM_CH-1:0] w_grantNext;
    logic              w_pushNext;
    cmd_op_e           w_opNext;
    logic [CH_W-1:0]   w_chNext;
    logic [ADDR_W-1:0] w_addrNext;
    logic [DATA_W-1:0] w_dataNext;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_addrArr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign w_dataArr[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    // A channel shown its grant this cycle is masked so a held request is not served twice.
    assign w_elig = req_valid & ~r_grant;

`ifdef ARB_WRITE_PRIORITY_EN
    assign w_cand = (|(w_elig & req_write)) ? (w_elig & req_write) : w_elig;
`else
    assign w_cand = w_elig;
`endif

    assign w_issue = !fifo_full && (|w_cand);
    assign w_stall = fifo_full && (|w_elig);

    // Scan upward from the channel after the last winner, wrapping at NUM_CH-1.
    always_comb begin
        w_found   = 1'b0;
        w_scanIdx = '0;
        w_selIdx  = '0;
        for (int off = 1; off <= NUM_CH; off++) begin
            w_scanIdx = CH_W'((int'(r_lastGrant) + off) % NUM_CH);
            if (!w_found && w_cand[w_scanIdx]) begin
                w_found  = 1'b1;
                w_selIdx = w_scanIdx;
            end
        end
    end

    always_comb begin
        w_grantNext = '0;
        w_pushNext  = 1'b0;
        w_opNext    = OP_NOP;
        w_chNext    = '0;
        w_addrNext  = '0;
        w_dataNext  = '0;
        if (w_issue) begin
            w_grantNext[w_selIdx] = 1'b1;
            w_pushNext            = 1'b1;
            w_chNext              = w_selIdx;
            w_addrNext            = w_addrArr[w_selIdx];
            if (req_write[w_selIdx]) begin
                w_opNext   = OP_WRITE;
                w_dataNext = w_dataArr[w_selIdx];
            end else begin
                w_opNext   = OP_READ;
            end
        end
    end

    // Pointer resets to the top channel so channel 0 is first in line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant     <= '0;
            r_cmdPush   <= 1'b0;
            r_cmdOp     <= OP_NOP;
            r_cmdCh     <= '0;
            r_cmdAddr   <= '0;
            r_cmdWdata  <= '0;
            r_stallCnt  <= '0;
            r_lastGrant <= CH_W'(NUM_CH - 1);
        end else begin
            r_grant    <= w_grantNext;
            r_cmdPush  <= w_pushNext;
            r_cmdOp    <= w_opNext;
            r_cmdCh    <= w_chNext;
            r_cmdAddr  <= w_addrNext;
            r_cmdWdata <= w_dataNext;
            if (w_issue) begin
                r_lastGrant <= w_selIdx;
            end
            if (w_stall && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
        end
    end

    assign grant     = r_grant;
    assign cmd_push  = r_cmdPush;
    assign cmd_op    = r_cmdOp;
    assign cmd_ch    = r_cmdCh;
    assign cmd_addr  = r_cmdAddr;
    assign cmd_wdata = r_cmdWdata;
    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_apb_cmd_arbiter.sv
// Testbench for apb_cmd_arbiter: directed scenarios plus random traffic against a request-level model.
// Expectations follow ARB_WRITE_PRIORITY_EN when it is defined for the build.
module tb_apb_cmd_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              resetN;
    logic [NCH-1:0]    reqValid;
    logic [NCH-1:0]    reqWrite;
    logic [NCH*AW-1:0] reqAddr;
    logic [NCH*DW-1:0] reqWdata;
    logic              fifoFull;
    logic [NCH-1:0]    grant;
    logic              cmdPush;
    logic [1:0]        cmdOp;
    logic [1:0]        cmdCh;
    logic [AW-1:0]     cmdAddr;
    logic [DW-1:0]     cmdWdata;
    logic [15:0]       stallCnt;

    int total = 0;
    int bad   = 0;

    int             mLast;
    logic [NCH-1:0] mGrant;
    int             mStall;
    logic [NCH-1:0] eGrant;
    logic           ePush;
    logic [1:0]     eOp;
    logic [1:0]     eCh;
    logic [AW-1:0]  eAddr;
    logic [DW-1:0]  eData;

    apb_cmd_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset     (resetN),
        .req_valid (reqValid),
        .req_write (reqWrite),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .fifo_full (fifoFull),
        .grant     (grant),
        .cmd_push  (cmdPush),
        .cmd_op    (cmdOp),
        .cmd_ch    (cmdCh),
        .cmd_addr  (cmdAddr),
        .cmd_wdata (cmdWdata),
        .stall_cnt (stallCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, "_grant"}, grant, eGrant);
        checkOne({tag, "_push"},  cmdPush, ePush);
        checkOne({tag, "_op"},    cmdOp, eOp);
        checkOne({tag, "_ch"},    cmdCh, eCh);
        checkOne({tag, "_addr"},  cmdAddr, eAddr);
        checkOne({tag, "_wdata"}, cmdWdata, eData);
        checkOne({tag, "_stall"}, stallCnt, mStall[15:0]);
    endtask

    task automatic checkAllZero(input string tag);
        checkOne({tag, "_grant"}, grant, 0);
        checkOne({tag, "_push"},  cmdPush, 0);
        checkOne({tag, "_op"},    cmdOp, 0);
        checkOne({tag, "_ch"},    cmdCh, 0);
        checkOne({tag, "_addr"},  cmdAddr, 0);
        checkOne({tag, "_wdata"}, cmdWdata, 0);
        checkOne({tag, "_stall"}, stallCnt, 0);
    endtask

    task automatic modelReset();
        mLast  = NCH - 1;
        mGrant = '0;
        mStall = 0;
    endtask

    // Predict the next edge from the request rules, advance one clock, then compare.
    task automatic applyStimulus(input string tag);
        logic [NCH-1:0] elig;
        logic [NCH-1:0] cand;
        int             sel;
        elig = reqValid & ~mGrant;
        cand = elig;
`ifdef ARB_WRITE_PRIORITY_EN
        if ((elig & reqWrite) != '0) cand = elig & reqWrite;
`endif
        eGrant = '0; ePush = 1'b0; eOp = 2'b00; eCh = 2'd0; eAddr = '0; eData = '0;
        if (fifoFull) begin
            if (elig != '0 && mStall < 65535) mStall++;
        end else if (cand != '0) begin
            sel = -1;
            for (int k = 1; k <= NCH; k++) begin
                int c;
                c = (mLast + k) % NCH;
                if (sel < 0 && cand[c]) sel = c;
            end
            mLast             = sel;
            eGrant[sel[1:0]]  = 1'b1;
            ePush             = 1'b1;
            eCh               = sel[1:0];
            eAddr             = reqAddr[sel*AW +: AW];
            eOp               = reqWrite[sel] ? 2'b10 : 2'b01;
            eData             = reqWrite[sel] ? reqWdata[sel*DW +: DW] : '0;
        end
        @(posedge clk);
        #1;
        mGrant = eGrant;
        checkOutput(tag);
    endtask

    task automatic setReq(input int ch, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        reqWrite[ch]          = wr;
        reqAddr[ch*AW +: AW]  = a;
        reqWdata[ch*DW +: DW] = d;
    endtask

    task automatic doReset(input string tag);
        resetN   = 1'b0;
        reqValid = '0;
        reqWrite = '0;
        reqAddr  = '0;
        reqWdata = '0;
        fifoFull = 1'b0;
        #1;
        checkAllZero(tag);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        modelReset();
    endtask

    initial begin
        logic [NCH-1:0] expG;
        int             firstCh;
        int             secondCh;

        resetN   = 1'b1;
        reqValid = '0;
        reqWrite = '0;
        reqAddr  = '0;
        reqWdata = '0;
        fifoFull = 1'b0;
        modelReset();
        #2;
        doReset("rst0");

        // Single read on channel 0 right after reset.
        setReq(0, 1'b0, 8'h10, 32'h1234_5678);
        reqValid = 4'b0001;
        applyStimulus("first");
        checkOne("first_grant", grant, 4'b0001);
        checkOne("first_push",  cmdPush, 1);
        checkOne("first_op",    cmdOp, 2'b01);
        checkOne("first_ch",    cmdCh, 0);
        checkOne("first_addr",  cmdAddr, 8'h10);
        checkOne("first_wdata", cmdWdata, 0);
        reqValid = '0;
        applyStimulus("idle");
        checkOne("idle_push", cmdPush, 0);
        checkOne("idle_addr", cmdAddr, 0);

        // Sustained requests on all channels rotate with no gaps.
        doReset("rst1");
        for (int i = 0; i < NCH; i++) setReq(i, 1'b0, 8'(8'h40 + i), 32'(i + 1));
        reqValid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            applyStimulus("rr");
            expG = 4'b0001 << (k % NCH);
            checkOne("rr_order", grant, expG);
            checkOne("rr_push", cmdPush, 1);
        end

        // Full FIFO blocks channel 2 for five cycles.
        doReset("rst2");
        setReq(2, 1'b0, 8'h22, 32'h0);
        reqValid = 4'b0100;
        fifoFull = 1'b1;
        repeat (5) begin
            applyStimulus("full");
            checkOne("full_nopush", cmdPush, 0);
        end
        checkOne("stall5", stallCnt, 5);
        fifoFull = 1'b0;
        applyStimulus("release");
        checkOne("release_grant", grant, 4'b0100);
        reqValid = '0;
        applyStimulus("after_release");
        checkOne("stall_hold", stallCnt, 5);

        // Read on ch0 against write on ch3.
        doReset("rst3");
        setReq(0, 1'b0, 8'h20, 32'h5555_5555);
        setReq(3, 1'b1, 8'h33, 32'hDEAD_BEEF);
        reqValid = 4'b1001;
`ifdef ARB_WRITE_PRIORITY_EN
        firstCh  = 3;
        secondCh = 0;
`else
        firstCh  = 0;
        secondCh = 3;
`endif
        applyStimulus("prio1");
        checkOne("prio1_ch", cmdCh, firstCh);
        checkOne("prio1_op", cmdOp, (firstCh == 3) ? 2'b10 : 2'b01);
        checkOne("prio1_wdata", cmdWdata, (firstCh == 3) ? 32'hDEAD_BEEF : 32'h0);
        reqValid[firstCh] = 1'b0;
        applyStimulus("prio2");
        checkOne("prio2_ch", cmdCh, secondCh);
        checkOne("prio2_op", cmdOp, (secondCh == 3) ? 2'b10 : 2'b01);
        reqValid = '0;

        // Reset pulse in the middle of a sustained stream.
        doReset("rst4");
        for (int i = 0; i < NCH; i++) setReq(i, 1'b0, 8'(8'h80 + i), 32'h0);
        reqValid = 4'b1111;
        applyStimulus("pre_rst");
        applyStimulus("pre_rst");
        #2;
        resetN = 1'b0;
        #1;
        checkAllZero("midrst");
        @(posedge clk);
        #1;
        resetN = 1'b1;
        modelReset();
        applyStimulus("post_rst");
        checkOne("post_rst_grant", grant, 4'b0001);

        // Random traffic; requesters drop or renew once the model says they were granted.
        doReset("rst5");
        repeat (400) begin
            for (int c = 0; c < NCH; c++) begin
                if (mGrant[c]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        reqValid[c] = 1'b1;
                        setReq(c, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
                    end else begin
                        reqValid[c] = 1'b0;
                    end
                end else if (!reqValid[c] && $urandom_range(0, 1) == 0) begin
                    reqValid[c] = 1'b1;
                    setReq(c, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
                end
            end
            fifoFull = ($urandom_range(0, 3) == 0);
            applyStimulus("rand");
        end

        // Stall counter saturation.
        doReset("rst6");
        reqValid = 4'b0001;
        fifoFull = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        checkOne("stall_sat", stallCnt, 16'hFFFF);
        checkOne("sat_nopush", cmdPush, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
